// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sequencing N requesters onto cache channel 1.
// Optional macro CACHE_ARB_STATS_EN adds saturating read/write/evict statistics counters.
module cache_port_arbiter #(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0]               req_valid,
  input  logic [N-1:0]               req_write,
  input  logic [N*ADDR_WIDTH-1:0]    req_addr,
  input  logic [N*LINE_WIDTH-1:0]    req_data,
  output logic [N-1:0]               req_ready,
  output logic [N-1:0]               resp_valid,
  output logic                       resp_hit,
  output logic [LINE_WIDTH-1:0]      resp_data,
  output logic [ADDR_WIDTH-1:0]      cache_addr,
  output logic [LINE_WIDTH-1:0]      cache_wdata,
  output logic                       cache_read,
  output logic                       cache_write,
  input  logic                       cache_hit,
  input  logic [LINE_WIDTH-1:0]      cache_rdata,
  output logic                       busy
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [15:0]                stat_reads,
  output logic [15:0]                stat_read_hits,
  output logic [15:0]                stat_writes,
  output logic [15:0]                stat_write_evicts
`endif
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state, state_next;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          sel;
  logic [PW:0]            idx_w;
  logic                   any_req;
  logic                   op_write;
  logic                   wait_extra;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  data_q;

  // Scan downward so the last match kept is the first set bit at/after rr_ptr.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx_w   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_w = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx_w >= (PW+1)'(N)) idx_w = idx_w - (PW+1)'(N);
      if (req_valid[idx_w[PW-1:0]]) begin
        any_req = 1'b1;
        sel     = idx_w[PW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_req) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (!op_write || cache_hit) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    resp_valid  = '0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    busy        = (state != S_IDLE);
    cache_addr  = addr_q;
    cache_wdata = data_q;
    case (state)
      S_IDLE:  if (any_req) req_ready[sel] = 1'b1;
      S_ISSUE: begin
        cache_read  = !op_write;
        cache_write = op_write;
      end
      // Keep write asserted while the eviction is still in progress.
      S_WAIT:  cache_write = op_write && !cache_hit;
      S_RESP:  resp_valid[gnt_idx] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      op_write   <= 1'b0;
      wait_extra <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          gnt_idx    <= sel;
          op_write   <= req_write[sel];
          addr_q     <= req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          data_q     <= req_data[sel*LINE_WIDTH +: LINE_WIDTH];
          wait_extra <= 1'b0;
        end
        S_WAIT: begin
          if (!op_write) begin
            resp_hit  <= cache_hit;
            resp_data <= cache_rdata;
          end else if (cache_hit) begin
            resp_hit <= 1'b1;
          end else begin
            wait_extra <= 1'b1;
          end
        end
        S_RESP: rr_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads        <= '0;
      stat_read_hits    <= '0;
      stat_writes       <= '0;
      stat_write_evicts <= '0;
    end else if (state == S_RESP) begin
      if (!op_write) begin
        stat_reads <= sat_inc(stat_reads);
        if (resp_hit) stat_read_hits <= sat_inc(stat_read_hits);
      end else begin
        stat_writes <= sat_inc(stat_writes);
        if (wait_extra) stat_write_evicts <= sat_inc(stat_write_evicts);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed scoreboard bench for cache_port_arbiter (N=4 and N=3 instances).
module tb_cache_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int LW = 32;

  typedef struct {
    logic [N-1:0] mask;
    logic         hit;
    logic [LW-1:0] data;
    bit           chk_data;
    int           cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;
  exp_t sb[$];

  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic            resp_hit, cache_read, cache_write, busy;
  logic [LW-1:0]   resp_data, cache_wdata;
  logic [AW-1:0]   cache_addr;
  logic            cache_hit = 1'b0;
  logic [LW-1:0]   cache_rdata = '0;

  logic [2:0]      rv3 = '0;
  logic [2:0]      rw3 = '0;
  logic [3*AW-1:0] ra3 = '0;
  logic [3*LW-1:0] rd3 = '0;
  logic [2:0]      ready3, respv3;
  logic            rhit3, cread3, cwrite3, busy3;
  logic [LW-1:0]   rdata3, cwdata3;
  logic [AW-1:0]   caddr3;
  logic            chit3 = 1'b0;
  logic [LW-1:0]   crdata3 = '0;

`ifdef CACHE_ARB_STATS_EN
  logic [15:0] st_r, st_rh, st_w, st_we, st3_r, st3_rh, st3_w, st3_we;
`endif

  // Registered cache model: a write reports hit once miss_cfg extra cycles have passed.
  logic model_hit = 1'b1;
  logic [LW-1:0] model_rdata = '0;
  int miss_cfg = 0;
  int wcnt = 0;
  always @(posedge clock) begin
    if (cache_read) begin
      cache_hit   <= model_hit;
      cache_rdata <= model_rdata;
    end
    if (cache_write) begin
      cache_hit <= (wcnt >= miss_cfg);
      wcnt      <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
    if (cread3) chit3 <= 1'b1;
  end

  cache_port_arbiter #(.N(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_read(cache_read),
    .cache_write(cache_write), .cache_hit(cache_hit), .cache_rdata(cache_rdata), .busy(busy)
`ifdef CACHE_ARB_STATS_EN
    , .stat_reads(st_r), .stat_read_hits(st_rh), .stat_writes(st_w), .stat_write_evicts(st_we)
`endif
  );

  cache_port_arbiter #(.N(3), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(rv3), .req_write(rw3), .req_addr(ra3), .req_data(rd3),
    .req_ready(ready3), .resp_valid(respv3), .resp_hit(rhit3), .resp_data(rdata3),
    .cache_addr(caddr3), .cache_wdata(cwdata3), .cache_read(cread3),
    .cache_write(cwrite3), .cache_hit(chit3), .cache_rdata(crdata3), .busy(busy3)
`ifdef CACHE_ARB_STATS_EN
    , .stat_reads(st3_r), .stat_read_hits(st3_rh), .stat_writes(st3_w), .stat_write_evicts(st3_we)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    check("rw_exclusive", {63'd0, cache_read & cache_write}, 64'd0);
    if (!reset && resp_valid != '0) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {60'd0, resp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_mask", {60'd0, resp_valid}, {60'd0, e.mask});
        check("resp_hit", {63'd0, resp_hit}, {63'd0, e.hit});
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk_data) check("resp_data", {32'd0, resp_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    logic [N-1:0] m;
    int nw;

    tick();
    tick();
    settle();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    check("rst_cache_rw", {62'd0, cache_read, cache_write}, 64'd0);
    check("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    check("rst_resp_data", {32'd0, resp_data}, 64'd0);
    check("rst_busy3", {63'd0, busy3}, 64'd0);
    tick();
    reset = 1'b0;

    // Read hit from requester 0.
    tick();
    req_valid = 4'b0001; req_write = 4'b0000; req_addr[0 +: AW] = 8'h10;
    model_hit = 1'b1; model_rdata = 32'hDEADBEEF;
    settle();
    check("t1_ready", {60'd0, req_ready}, 64'h1);
    check("t1_rd_c0", {63'd0, cache_read}, 64'd0);
    sb.push_back('{4'b0001, 1'b1, 32'hDEADBEEF, 1'b1, cyc + 3});
    tick();
    req_valid = '0;
    settle();
    check("t1_rd_c1", {63'd0, cache_read}, 64'd1);
    check("t1_addr", {56'd0, cache_addr}, 64'h10);
    check("t1_ready_issue", {60'd0, req_ready}, 64'd0);
    tick();
    settle();
    check("t1_rd_c2", {63'd0, cache_read}, 64'd0);
    tick();
    settle();
    check("t1_busy_resp", {63'd0, busy}, 64'd1);
    tick();
    settle();
    check("t1_busy_idle", {63'd0, busy}, 64'd0);

    // Write hit from requester 1.
    tick();
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[1*AW +: AW] = 8'h22; req_data[1*LW +: LW] = 32'h12345678; miss_cfg = 0;
    settle();
    check("t2_ready", {60'd0, req_ready}, 64'h2);
    sb.push_back('{4'b0010, 1'b1, 32'h0, 1'b0, cyc + 3});
    nw = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      settle();
      if (cache_write) nw++;
      if (k == 1) begin
        check("t2_addr", {56'd0, cache_addr}, 64'h22);
        check("t2_wdata", {32'd0, cache_wdata}, 64'h12345678);
      end
    end
    check("t2_write_cycles", 64'(nw), 64'd1);

    // Write miss from requester 2: three extra WAIT cycles.
    tick();
    req_valid = 4'b0100; req_write = 4'b0100;
    req_addr[2*AW +: AW] = 8'h33; req_data[2*LW +: LW] = 32'hCAFEF00D; miss_cfg = 3;
    settle();
    check("t3_ready", {60'd0, req_ready}, 64'h4);
    sb.push_back('{4'b0100, 1'b1, 32'h0, 1'b0, cyc + 6});
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      settle();
      check($sformatf("t3_write_c%0d", k), {63'd0, cache_write}, {63'd0, k <= 4});
      if (k <= 4) begin
        check($sformatf("t3_addr_c%0d", k), {56'd0, cache_addr}, 64'h33);
        check($sformatf("t3_wdata_c%0d", k), {32'd0, cache_wdata}, 64'hCAFEF00D);
      end
    end
`ifdef CACHE_ARB_STATS_EN
    tick();
    settle();
    check("stat_reads", {48'd0, st_r}, 64'd1);
    check("stat_read_hits", {48'd0, st_rh}, 64'd1);
    check("stat_writes", {48'd0, st_w}, 64'd2);
    check("stat_write_evicts", {48'd0, st_we}, 64'd1);
`endif

    // Read miss from requester 3 (moves rr_ptr back to 0).
    tick();
    req_valid = 4'b1000; req_write = '0; req_addr[3*AW +: AW] = 8'h44; model_hit = 1'b0;
    settle();
    check("t4_ready", {60'd0, req_ready}, 64'h8);
    sb.push_back('{4'b1000, 1'b0, 32'h0, 1'b0, cyc + 3});
    tick();
    req_valid = '0;
    tick();
    tick();

    // All requesters hold valid: expect grants 0,1,2,3,0.
    tick();
    req_valid = 4'hF; req_write = '0; model_hit = 1'b1; model_rdata = 32'h0BADF00D;
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) tick();
      settle();
      if (t % 4 == 0) begin
        m = 4'b0001 << ((t / 4) % 4);
        check($sformatf("rr_grant%0d", t / 4), {60'd0, req_ready}, {60'd0, m});
        sb.push_back('{m, 1'b1, 32'h0BADF00D, 1'b1, cyc + 3});
      end else begin
        check($sformatf("rr_noready%0d", t), {60'd0, req_ready}, 64'd0);
      end
    end
    tick();
    req_valid = '0;
    tick();
    tick();

    // Reset during a long write miss from requester 1.
    tick();
    req_valid = 4'b0010; req_write = 4'b0010; req_addr[1*AW +: AW] = 8'h55; miss_cfg = 20;
    settle();
    check("t5_ready", {60'd0, req_ready}, 64'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    settle();
    check("t5_write_before_rst", {63'd0, cache_write}, 64'd1);
    tick();
    reset = 1'b0;
    settle();
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_write", {63'd0, cache_write}, 64'd0);
    check("t5_resp_valid", {60'd0, resp_valid}, 64'd0);
    check("t5_resp_hit", {63'd0, resp_hit}, 64'd0);
    tick();
    req_valid = 4'b0011; req_write = '0; req_addr[0 +: AW] = 8'h66; model_rdata = 32'h600DCAFE;
    settle();
    check("t5_ready_after_rst", {60'd0, req_ready}, 64'h1);
    sb.push_back('{4'b0001, 1'b1, 32'h600DCAFE, 1'b1, cyc + 3});
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    settle();
    check("t5_idle", {63'd0, busy}, 64'd0);

    // N=3: grant 2, then pointer wraps to 0.
    tick();
    rv3 = 3'b100;
    settle();
    check("n3_ready2", {61'd0, ready3}, 64'h4);
    tick();
    rv3 = '0;
    tick();
    tick();
    settle();
    check("n3_resp2", {61'd0, respv3}, 64'h4);
    tick();
    rv3 = 3'b101;
    settle();
    check("n3_ready_wrap", {61'd0, ready3}, 64'h1);
    tick();
    rv3 = '0;
    tick();
    tick();
    settle();
    check("n3_resp0", {61'd0, respv3}, 64'h1);
    tick();
    settle();
    check("n3_idle", {63'd0, busy3}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
